// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared grant-state encoding and starvation counter width.
package dmem_arbiter_pkg;
   localparam logic ST_GNT_CORE = 1'b0;
   localparam logic ST_GNT_DBG = 1'b1;
   localparam int CNT_W = 4;
   typedef enum logic {GNT_CORE = ST_GNT_CORE, GNT_DBG = ST_GNT_DBG} state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core load/store, debug port and D_MEM bus of the arbiter.
//  slave  = arbiter side (takes c_*/d_* requests and m_rdata, drives grants and m_*)
//  master = core/debug/memory side
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic c_req, c_we, c_stall;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata, c_rdata;
   logic d_valid, d_we, d_lock, d_ready, d_rvalid, d_halt, halted;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   modport slave (
      input c_req, c_we, c_addr, c_wdata, d_valid, d_we, d_lock, d_addr, d_wdata, d_halt, m_rdata,
      output c_rdata, c_stall, d_ready, d_rvalid, d_rdata, halted, m_we, m_addr, m_wdata
   );
   modport master (
      output c_req, c_we, c_addr, c_wdata, d_valid, d_we, d_lock, d_addr, d_wdata, d_halt, m_rdata,
      input c_rdata, c_stall, d_ready, d_rvalid, d_rdata, halted, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// dmem_arbiter_starve_counter: counts consecutive contended core wins.
//  clk, rst : clock, synchronous active-high reset
//  en       : core won a contended cycle
//  clr      : return count to zero
//  tc       : count has reached MAX_WAIT-1 (this win forces the debug grant)
module dmem_arbiter_starve_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);
   logic [CNT_W-1:0] cnt;
   assign tc = cnt == CNT_W'(MAX_WAIT - 1);
   always_ff @(posedge clk)
      cnt <= (rst | clr | (en & tc)) ? '0 : cnt + CNT_W'(en);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port D_MEM between the core load/store path and a debug port.
//  clk, rst : clock, synchronous active-high reset
//  bus      : core (c_*), debug (d_*, halt) and memory (m_*) signals, slave side
//  MAX_WAIT : contended core wins (1..15) before debug is forced in
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input logic clk,
   input logic rst,
   dmem_arbiter_if.slave bus
);
   state_t state;
   logic halt_q, gnt, inc, tc;
   always_comb begin
      gnt = ~rst & bus.d_valid & ((state == GNT_DBG) | halt_q | ~bus.c_req);
      inc = (state == GNT_CORE) & bus.c_req & bus.d_valid & ~halt_q;
   end
   dmem_arbiter_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt (
      .clk(clk), .rst(rst), .en(inc), .clr(~inc), .tc(tc)
   );
   assign bus.d_ready = gnt;
   assign bus.c_stall = ~rst & (halt_q | (bus.c_req & gnt));
   // a stalled core store is held off and retried by the core, so it lands after the debug beat
   assign bus.m_we = gnt ? bus.d_we : ~rst & bus.c_req & bus.c_we & ~bus.c_stall;
   assign bus.m_addr = gnt ? bus.d_addr : bus.c_addr;
   assign bus.m_wdata = gnt ? bus.d_wdata : bus.c_wdata;
   assign bus.c_rdata = bus.m_rdata;
   assign bus.halted = halt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GNT_CORE;
         halt_q <= 1'b0;
         bus.d_rvalid <= 1'b0;
         bus.d_rdata <= '0;
      end else begin
         state <= (state == GNT_DBG) ? ((bus.d_valid & bus.d_lock) ? GNT_DBG : GNT_CORE)
                                     : ((inc & tc) ? GNT_DBG : GNT_CORE);
         halt_q <= bus.d_halt;
         bus.d_rvalid <= gnt & ~bus.d_we;
         if (gnt & ~bus.d_we) bus.d_rdata <= bus.m_rdata;
      end
   end
endmodule
